// File: rtl/ca6_atan2.sv
// Iterative CORDIC vectoring core: out_ans = atan2(in_y, in_x) in Q8.8 radians (pi = 16'h0324).
// Same level-sensitive start/done handshake as the forward trig core.
module ca6_atan2 #(
    parameter int unsigned ITER  = 12,
    parameter int unsigned GUARD = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] in_x,
    input  logic [15:0] in_y,
    output logic [15:0] out_ans,
    output logic        done,
    output logic        busy
);

    localparam int unsigned DW     = 16;
    localparam int unsigned XW     = 18;
    localparam int unsigned ZW     = 16 + GUARD;
    localparam int unsigned IW     = 4;
    localparam int unsigned HALF_I = (32'd1 << GUARD) >> 1;

    // Angle constants are tabulated in Q3.12 and rescaled to the accumulator's fraction width.
    localparam logic signed [ZW-1:0] PI_Z    = $signed(ZW'((32'd12868 << GUARD) >> 4));
    localparam logic signed [ZW-1:0] HALF    = $signed(ZW'(HALF_I));
    localparam logic signed [ZW-1:0] ANS_MAX = $signed(ZW'(804));
    localparam logic signed [ZW-1:0] ANS_MIN = -$signed(ZW'(804));

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ITER,
        S_POST,
        S_DONE
    } state_t;

    // atan(2^-i) lookup in accumulator units
    function automatic logic signed [ZW-1:0] atan_at(input logic [IW-1:0] idx);
        int unsigned q12;
        case (idx)
            4'd0:    q12 = 32'd3217;
            4'd1:    q12 = 32'd1899;
            4'd2:    q12 = 32'd1003;
            4'd3:    q12 = 32'd509;
            4'd4:    q12 = 32'd256;
            4'd5:    q12 = 32'd128;
            4'd6:    q12 = 32'd64;
            4'd7:    q12 = 32'd32;
            4'd8:    q12 = 32'd16;
            4'd9:    q12 = 32'd8;
            4'd10:   q12 = 32'd4;
            4'd11:   q12 = 32'd2;
            default: q12 = 32'd0;
        endcase
        return $signed(ZW'((q12 << GUARD) >> 4));
    endfunction

    state_t                 state_q, state_d;
    logic signed [XW-1:0]   x_q, x_d, y_q, y_d;
    logic signed [XW-1:0]   xs, ys;
    logic signed [ZW-1:0]   z_q, z_d;
    logic signed [ZW-1:0]   atan_z, rnd;
    logic [IW-1:0]          i_q, i_d;
    logic                   zero_q, zero_d;
    logic [DW-1:0]          ans_d;
    logic                   done_d, busy_d;
    logic                   dir;

    // Next-state, datapath and output logic
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        zero_d  = zero_q;
        ans_d   = out_ans;
        done_d  = done;
        xs      = x_q >>> i_q;
        ys      = y_q >>> i_q;
        atan_z  = atan_at(i_q);
        rnd     = (z_q + HALF) >>> GUARD;
        dir     = ~y_q[XW-1];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = $signed({{(XW-DW){in_x[DW-1]}}, in_x});
                    y_d     = $signed({{(XW-DW){in_y[DW-1]}}, in_y});
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                // Fold the left half-plane onto the right one; 18 bits hold -(-32768).
                zero_d = (x_q == '0) && (y_q == '0);
                i_d    = '0;
                if (x_q[XW-1]) begin
                    x_d = -x_q;
                    y_d = -y_q;
                    z_d = y_q[XW-1] ? -PI_Z : PI_Z;
                end else begin
                    z_d = '0;
                end
                state_d = S_ITER;
            end
            S_ITER: begin
                if (dir) begin
                    x_d = x_q + ys;
                    y_d = y_q - xs;
                    z_d = z_q + atan_z;
                end else begin
                    x_d = x_q - ys;
                    y_d = y_q + xs;
                    z_d = z_q - atan_z;
                end
                if (i_q == IW'(ITER - 1)) begin
                    state_d = S_POST;
                end else begin
                    i_d = i_q + IW'(1);
                end
            end
            S_POST: begin
                // A zero vector has no direction; report 0 rather than the accumulated table sum.
                if (zero_q) begin
                    ans_d = '0;
                end else if (rnd > ANS_MAX) begin
                    ans_d = DW'(ANS_MAX);
                end else if (rnd < ANS_MIN) begin
                    ans_d = DW'(ANS_MIN);
                end else begin
                    ans_d = DW'(rnd);
                end
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!start) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                done_d  = 1'b0;
            end
        endcase

        busy_d = (state_d == S_PRE) || (state_d == S_ITER) || (state_d == S_POST);
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            zero_q  <= 1'b0;
            out_ans <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            zero_q  <= zero_d;
            out_ans <= ans_d;
            done    <= done_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_ca6_atan2.sv
// Randomized and directed bench for ca6_atan2 against a real-valued atan2 reference.
module tb_ca6_atan2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] in_x, in_y;
    logic [15:0] out_ans;
    logic        done, busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ca6_atan2 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .in_x    (in_x),
        .in_y    (in_y),
        .out_ans (out_ans),
        .done    (done),
        .busy    (busy)
    );

    // Single comparison point: |got - exp| must be within tol
    task automatic check_val(input string tag, input int got, input int exp, input int tol);
        int diff;
        n_cmp++;
        diff = got - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic int sx(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    // Reference: ideal atan2 in Q8.8, rounded half-up, clipped to [-pi, +pi]
    function automatic int ref_ans(input logic [15:0] x, input logic [15:0] y);
        real a;
        int  r;
        if (x == 16'h0000 && y == 16'h0000) return 0;
        a = $atan2($itor(sx(y)), $itor(sx(x)));
        r = $rtoi($floor(a * 256.0 + 0.5));
        if (r > 804)  r = 804;
        if (r < -804) r = -804;
        return r;
    endfunction

    // One transaction: start held for 'hold' edges after acceptance, operands scrambled mid-flight
    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input int hold,
                          input int tol, input string tag);
        int edges;
        int prev;
        int exp;
        exp  = ref_ans(x, y);
        prev = sx(out_ans);
        @(negedge clk);
        in_x  = x;
        in_y  = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        edges = 0;
        in_x  = 16'($urandom);
        in_y  = 16'($urandom);
        if (hold <= 0) start = 1'b0;
        check_val({tag, ".busy"}, int'(busy), 1, 0);
        while (!done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == hold) start = 1'b0;
            if (edges == 6) check_val({tag, ".hold_ans"}, sx(out_ans), prev, 0);
        end
        check_val({tag, ".latency"}, edges, 14, 0);
        check_val({tag, ".ans"}, sx(out_ans), exp, tol);
        check_val({tag, ".idle_busy"}, int'(busy), 0, 0);
        if (start) begin
            repeat (3) @(posedge clk);
            #1;
            check_val({tag, ".done_held"}, int'(done), 1, 0);
            check_val({tag, ".no_restart"}, int'(busy), 0, 0);
            start = 1'b0;
        end
        @(posedge clk);
        #1;
        check_val({tag, ".done_clr"}, int'(done), 0, 0);
    endtask

    initial begin
        logic [15:0] rx, ry;
        int          seen;
        rst_n = 1'b0;
        start = 1'b0;
        in_x  = '0;
        in_y  = '0;
        #22;
        check_val("rst.ans", sx(out_ans), 0, 0);
        check_val("rst.done", int'(done), 0, 0);
        check_val("rst.busy", int'(busy), 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'h0100, 16'h0100, 4, 1, "pi4");
        run_op(16'h0000, 16'h0200, 2, 1, "pi2");
        run_op(16'h0000, 16'hFE00, 1, 1, "mpi2");
        run_op(16'hFF00, 16'h0000, 3, 0, "pi");
        run_op(16'hFF00, 16'hFFFF, 2, 1, "mpi");
        run_op(16'h0000, 16'h0000, 1, 0, "zero");
        run_op(16'h8000, 16'h7FFF, 5, 1, "3pi4");
        run_op(16'h0400, 16'h0000, 0, 1, "xpos");
        run_op(16'h0300, 16'hFD00, 30, 1, "hold");
        run_op(16'h1234, 16'h0ABC, 14, 2, "hold14");

        // Reset during ITER (iteration 5) aborts with no done
        @(negedge clk);
        in_x  = 16'h2000;
        in_y  = 16'h1000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("abort.ans", sx(out_ans), 0, 0);
        check_val("abort.done", int'(done), 0, 0);
        check_val("abort.busy", int'(busy), 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen++;
        end
        check_val("abort.nodone", seen, 0, 0);
        run_op(16'h2000, 16'h1000, 3, 1, "after_rst");

        // Randomized operands with magnitude large enough for the datapath precision
        for (int k = 0; k < 30; k++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            if (sx(rx) > -4096 && sx(rx) < 4096 && sx(ry) > -4096 && sx(ry) < 4096)
                rx = rx ^ 16'h4000;
            run_op(rx, ry, int'($urandom_range(0, 20)), 2, $sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
